// File: rtl/iterative_divider_pkg.sv
// Shared types and sizing for the iterative divider: FSM state encoding,
// default operand width and the derived iteration-counter width.
package iterative_divider_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // Counter must hold DIV_WIDTH-1; keep at least one bit for degenerate widths.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int CNT_WIDTH_DEFAULT = cnt_width(DIV_WIDTH_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/iterative_divider_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if non-negative.
module iterative_divider_step
  import iterative_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_shifted;

  always_comb begin
    w_shifted = {i_rem, i_bit};
    o_q_bit   = (w_shifted >= {1'b0, i_divisor});
    // The true difference is below 2^WIDTH whenever it is kept, so the
    // truncated subtraction is exact.
    o_rem     = o_q_bit ? (w_shifted[WIDTH-1:0] - i_divisor) : w_shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle signed/unsigned restoring divider: one quotient bit per cycle,
// abortable by flush or reset, with registered quotient/remainder outputs.
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_start,
  input  logic                 i_signed,
  input  logic [DIV_WIDTH-1:0] i_dividend,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  input  logic                 i_flush,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [DIV_WIDTH-1:0] o_quotient,
  output logic [DIV_WIDTH-1:0] o_remainder
);

  localparam int             CNT_W    = cnt_width(DIV_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_WIDTH - 1);

  div_state_t r_state, w_state_next;

  logic [CNT_W-1:0]     r_cnt;
  logic [DIV_WIDTH-1:0] r_divisor, r_rem, r_quo, r_quotient, r_remainder;
  logic                 r_neg_q, r_neg_r, r_div_zero;

  logic                 w_accept, w_last, w_step_q;
  logic [DIV_WIDTH-1:0] w_dividend_mag, w_divisor_mag, w_step_rem;
  logic [DIV_WIDTH-1:0] w_quo_raw, w_quo_final, w_rem_final;

  // Requests are honoured only out of reset, outside BUSY and without a flush.
  assign w_accept = resetn & i_start & ~i_flush & (r_state != BUSY);
  assign w_last   = (r_state == BUSY) && (r_cnt == '0) && !i_flush;

  assign o_busy      = (r_state == BUSY) | w_accept;
  assign o_done      = (r_state == DONE);
  assign o_quotient  = r_quotient;
  assign o_remainder = r_remainder;

  assign w_dividend_mag = (i_signed && i_dividend[DIV_WIDTH-1]) ? (~i_dividend + 1'b1) : i_dividend;
  assign w_divisor_mag  = (i_signed && i_divisor[DIV_WIDTH-1])  ? (~i_divisor + 1'b1)  : i_divisor;

  iterative_divider_step #(.WIDTH(DIV_WIDTH)) u_step (
    .i_rem    (r_rem),
    .i_bit    (r_quo[DIV_WIDTH-1]),
    .i_divisor(r_divisor),
    .o_rem    (w_step_rem),
    .o_q_bit  (w_step_q)
  );

  // Divide-by-zero yields all-ones raw quotient; it must not be sign-fixed.
  assign w_quo_raw   = {r_quo[DIV_WIDTH-2:0], w_step_q};
  assign w_quo_final = (r_neg_q && !r_div_zero) ? (~w_quo_raw + 1'b1) : w_quo_raw;
  assign w_rem_final = r_neg_r ? (~w_step_rem + 1'b1) : w_step_rem;

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: assigning a default first guarantees no latch for paths that skip an assignment.
    w_state_next = r_state;
    unique case (r_state)
      IDLE, DONE: w_state_next = w_accept ? BUSY : IDLE;
      BUSY: begin
        if (i_flush)           w_state_next = IDLE;
        else if (r_cnt == '0)  w_state_next = DONE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt       <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_div_zero  <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else if (w_accept) begin
      r_cnt      <= CNT_LOAD;
      r_divisor  <= w_divisor_mag;
      r_quo      <= w_dividend_mag;
      r_rem      <= '0;
      r_neg_q    <= i_signed & (i_dividend[DIV_WIDTH-1] ^ i_divisor[DIV_WIDTH-1]);
      r_neg_r    <= i_signed & i_dividend[DIV_WIDTH-1];
      r_div_zero <= (i_divisor == '0);
    end else if (r_state == BUSY && !i_flush) begin
      r_rem <= w_step_rem;
      r_quo <= w_quo_raw;
      r_cnt <= r_cnt - 1'b1;
      if (w_last) begin
        r_quotient  <= w_quo_final;
        r_remainder <= w_rem_final;
      end
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed corner cases, flush,
// reset abort, back-to-back and randomized ops against an arithmetic model.
module tb_iterative_divider;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_start = 1'b0;
  logic        i_signed = 1'b0;
  logic        i_flush = 1'b0;
  logic [31:0] i_dividend = '0;
  logic [31:0] i_divisor = '0;
  logic        o_busy, o_done;
  logic [31:0] o_quotient, o_remainder;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iterative_divider #(.DIV_WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .i_start    (i_start),
    .i_signed   (i_signed),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .i_flush    (i_flush),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_quotient (o_quotient),
    .o_remainder(o_remainder)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic reference: plain division with the architectural corner rules.
  function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
  endfunction

  // Starts an op in the current cycle (T0) and returns during its done cycle
  // with i_start low; hold>0 keeps i_start asserted with junk operands into BUSY.
  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_q, input logic [31:0] exp_r,
                       input int hold, input string tag);
    int   n;
    logic busy_ok;
    i_signed   = sgn;
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    #1;
    check({tag, "/busy_t0"}, {31'd0, o_busy}, 32'd1);
    step();
    n       = 1;
    busy_ok = 1'b1;
    if (hold > 0) begin
      i_dividend = ~a;
      i_divisor  = 32'd3;
    end else begin
      i_start = 1'b0;
    end
    while (o_done !== 1'b1 && n < 40) begin
      if (o_busy !== 1'b1) busy_ok = 1'b0;
      if (n >= hold) i_start = 1'b0;
      step();
      n++;
    end
    i_start = 1'b0;
    #1;
    check({tag, "/latency"},  n, 32'd33);
    check({tag, "/busy_run"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "/done"},     {31'd0, o_done}, 32'd1);
    check({tag, "/busy_t33"}, {31'd0, o_busy}, 32'd0);
    check({tag, "/quot"},     o_quotient, exp_q);
    check({tag, "/rem"},      o_remainder, exp_r);
  endtask

  initial begin
    logic        s, seen;
    logic [31:0] a, b, eq, er;

    // Reset with a start request pending: must stay quiet.
    i_start = 1'b1;
    repeat (3) step();
    check("rst/busy", {31'd0, o_busy}, 32'd0);
    check("rst/done", {31'd0, o_done}, 32'd0);
    check("rst/quot", o_quotient, 32'd0);
    check("rst/rem",  o_remainder, 32'd0);
    i_start = 1'b0;
    resetn  = 1'b1;
    step();

    do_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0, "u100_7");
    step();
    check("u100_7/done_pulse", {31'd0, o_done}, 32'd0);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, "s-7_2");
    step();
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0, "s7_-2");
    step();
    do_op(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0, "u5_0");
    step();
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0, "s_ovf");
    step();
    do_op(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 0, "s-5_0");
    step();

    // Flush at T10 of 100/7: aborts silently, prior result (-5/0) retained.
    i_signed = 1'b0; i_dividend = 32'd100; i_divisor = 32'd7; i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (9) step();
    i_flush = 1'b1;
    #1;
    check("flush/busy_t10", {31'd0, o_busy}, 32'd1);
    step();
    i_flush = 1'b0;
    #1;
    check("flush/busy_t11", {31'd0, o_busy}, 32'd0);
    check("flush/done_t11", {31'd0, o_done}, 32'd0);
    check("flush/quot",     o_quotient, 32'hFFFF_FFFF);
    check("flush/rem",      o_remainder, 32'hFFFF_FFFB);
    seen = 1'b0;
    repeat (40) begin
      step();
      seen |= o_done;
    end
    check("flush/no_done", {31'd0, seen}, 32'd0);

    // Start together with flush in IDLE is dropped.
    i_start = 1'b1; i_flush = 1'b1;
    #1;
    check("startflush/busy", {31'd0, o_busy}, 32'd0);
    step();
    i_start = 1'b0; i_flush = 1'b0;
    #1;
    check("startflush/busy_next", {31'd0, o_busy}, 32'd0);

    // i_start held during BUSY must neither recapture nor restart.
    do_op(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 15, "hold");
    step();

    // Back-to-back: second request in the done cycle of the first.
    do_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0, "b2b1");
    do_op(1'b0, 32'd12345, 32'd100, 32'd123, 32'd45, 0, "b2b2");
    step();
    check("b2b2/done_pulse", {31'd0, o_done}, 32'd0);

    // Reset at T20 of an op: outputs cleared, no done, busy low while held.
    i_signed = 1'b0; i_dividend = 32'd1000; i_divisor = 32'd3; i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (19) step();
    resetn = 1'b0; i_start = 1'b1;
    step();
    check("rstmid/busy", {31'd0, o_busy}, 32'd0);
    check("rstmid/done", {31'd0, o_done}, 32'd0);
    check("rstmid/quot", o_quotient, 32'd0);
    check("rstmid/rem",  o_remainder, 32'd0);
    seen = 1'b0;
    repeat (5) begin
      step();
      seen |= o_done | o_busy;
    end
    resetn = 1'b1; i_start = 1'b0;
    repeat (20) begin
      step();
      seen |= o_done;
    end
    check("rstmid/quiet", {31'd0, seen}, 32'd0);

    // Randomized ops against the arithmetic model.
    for (int k = 0; k < 16; k++) begin
      s = 1'($urandom_range(0, 1));
      a = (k % 3 == 0) ? 32'($urandom_range(0, 500)) : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'($urandom_range(1, 15));
        1:       b = 32'd0;
        2:       b = 32'd0 - 32'($urandom_range(1, 100));
        default: b = $urandom;
      endcase
      ref_div(s, a, b, eq, er);
      do_op(s, a, b, eq, er, 0, $sformatf("rnd%0d", k));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iterative_divider.md
ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

Interface
REQ-001 Parameter DIV_WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 i_start  input  1  request a division; sampled only when not busy.
REQ-005 i_signed  input  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with i_start.
REQ-006 i_dividend  input  DIV_WIDTH  dividend; captured with i_start.
REQ-007 i_divisor  input  DIV_WIDTH  divisor; captured with i_start.
REQ-008 i_flush  input  1  pipeline exception abort; kills an operation in flight.
REQ-009 o_busy  output  1  stall request consumed by the pipeline controller to freeze all stage enables.
REQ-010 o_done  output  1  single-cycle pulse: results updated this cycle.
REQ-011 o_quotient  output  DIV_WIDTH  quotient (LO).
REQ-012 o_remainder  output  DIV_WIDTH  remainder (HI).

Function
REQ-013 FSM states IDLE, BUSY, DONE; SHALL leave reset in IDLE.
REQ-014 o_busy SHALL be combinational: 1 when state==BUSY, or when state is IDLE/DONE and i_start=1 and i_flush=0.
REQ-015 Accept cycle T0 (IDLE/DONE, i_start=1, i_flush=0): capture operands and i_signed, load iteration counter DIV_WIDTH-1, enter BUSY.
REQ-016 BUSY: one restoring-division quotient bit per cycle, MSB first; DIV_WIDTH cycles (T1..T32 at width 32).
REQ-017 On the BUSY cycle with counter 0: move to DONE; o_busy SHALL be 1 in every cycle T0..T32 (33 cycles) and 0 in T33.
REQ-018 DONE (T33): o_done=1 for exactly one cycle; o_quotient/o_remainder valid from T33 and held until the next o_done or reset.
REQ-019 DONE with no i_start -> IDLE next cycle; DONE with i_start -> back-to-back accept per REQ-015.
REQ-020 i_start while BUSY SHALL be ignored (no recapture, no restart).
REQ-021 Signed mode: divide magnitudes; quotient negated iff operand signs differ; remainder takes dividend sign.
REQ-022 Divisor zero (either mode): full latency, quotient all-ones, remainder = original dividend.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0, full latency, no trap.
REQ-024 i_flush=1 in BUSY: return to IDLE next cycle, o_busy=0 that next cycle, no o_done, output registers unchanged.
REQ-025 i_flush=1 together with i_start in IDLE/DONE: request dropped, o_busy=0, state -> IDLE.
REQ-026 Outputs o_quotient/o_remainder SHALL be registered; no combinational path from operand inputs to them.

Reset
REQ-027 resetn=0 at a clock edge: state IDLE, counter 0, o_done 0, o_quotient 0, o_remainder 0, captured operands 0.
REQ-028 Reset mid-BUSY SHALL abort with no o_done; o_busy=0 from the first cycle after the reset edge while resetn stays low (i_start ignored while resetn=0).

Structure
REQ-029 Shared package SHALL hold the state enum (IDLE/BUSY/DONE), DIV_WIDTH default and the derived counter width clog2(DIV_WIDTH).
REQ-030 One combinational sub-module iterative_divider_step SHALL implement a single shift/compare/subtract step (partial remainder in, next remainder and quotient bit out).
REQ-031 Magnitude conversion and final sign fix-up SHALL live in iterative_divider itself.

Verification
REQ-032 Unsigned 100/7 -> o_busy high 33 cycles, o_done at T33, quotient 14, remainder 2.
REQ-033 Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 -> quotient 0xFFFFFFFD, remainder 1.
REQ-034 5/0 unsigned -> quotient 0xFFFFFFFF, remainder 5; signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-035 Start 100/7, i_flush at T10 -> o_busy 0 at T11, no o_done, outputs keep prior result; i_start at T15 ignored-check: held with i_start during BUSY of a second op does not restart it.
REQ-036 Back-to-back: second i_start in T33 of first op -> second o_done at T66 with correct result; resetn low at T20 of an op -> outputs 0, no o_done.
